lockstep_compare_monitor: RTL and testbench
===========================================

Name: lockstep_compare_monitor

Overview:
Parametrised lockstep monitor comparing two implementations of the same circuit (A and B) lane by lane, for equivalence checking in simulation, formal and silicon debug. Generalises a single-bit, zero-latency equality check:
- N lanes of W bits.
- Configurable pipeline skew between A and B.
- Warm-up masking.
- Sticky fault state machine, saturating mismatch counter and first-failure capture.

Sits beside the two instances under comparison in verification tops and debug wrappers.

Parameters:
LANES, 2, number of compared output lanes
WIDTH, 1, bits per lane
SKEW, 0, cycles by which B lags A; A path is delayed SKEW cycles (0 = no delay)
CNT_W, 8, mismatch counter width
LIDX_W, $clog2(LANES+1), lane index width (derived; value LANES encodes valid mismatch)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
a_valid_i  in  1  A outputs valid
a_data_i  in  LANES*WIDTH  A outputs, lane k at [k*WIDTH +: WIDTH]
b_valid_i  in  1  B outputs valid
b_data_i  in  LANES*WIDTH  B outputs, same packing
clear_i  in  1  synchronous clear of monitor state
armed_o  out  1  state == ARMED or FAULT
mismatch_o  out  1  registered per-cycle mismatch pulse
lane_mism_o  out  LANES  registered per-lane mismatch vector
err_sticky_o  out  1  high once any mismatch seen (state FAULT)
mism_cnt_o  out  CNT_W  saturating count of mismatching compare cycles
first_lane_o  out  LIDX_W  lane of first mismatch
first_a_o  out  WIDTH  A lane value at first mismatch
first_b_o  out  WIDTH  B lane value at first mismatch

Behaviour:
- Clock and reset: one clock, clk; rst synchronous, active-high. Every flop updates on posedge clk only.
- Reset values: all outputs 0; delay line valid and data 0; state WARMUP.
- Delay line:
  - a_valid_i and a_data_i pass through SKEW register stages, giving da_valid and da_data.
  - SKEW=0: da_* = a_* combinationally.
- State machine:
  - WARMUP:
    - Warm-up counter counts max(SKEW,1) cycles, then state goes to ARMED.
    - All compares suppressed; mismatch_o and lane_mism_o stay 0.
  - ARMED:
    - Compare cycle: da_valid | b_valid_i.
    - Lane k mismatches when da_valid & b_valid_i and lane k of da_data != lane k of b_data.
    - Valid mismatch: da_valid != b_valid_i. Sets all lane_mism_o bits to 0 and mismatch_o to 1.
    - Any mismatch moves state to FAULT on the same edge that registers it.
  - FAULT:
    - Compares and counting continue.
    - Exit only via clear_i or rst.
- Latency: inputs at cycle t (B side) appear on mismatch_o and lane_mism_o at t+1. err_sticky_o and mism_cnt_o update on the same edge.
- Counter:
  - +1 per mismatching compare cycle, not per lane.
  - Saturates at 2^CNT_W-1 with no wrap.
- First capture:
  - Latched only on the ARMED->FAULT transition.
  - first_lane_o = lowest-index mismatching lane, or LANES for a valid mismatch.
  - first_a_o and first_b_o hold that lane's values; both are 0 for a valid mismatch.
  - Held until clear_i or rst.
- clear_i:
  - Same effect as rst on monitor state: counter, sticky, captures, delay line, and state back to WARMUP.
  - Input sampling resumes after warm-up.
- Precedence: rst > clear_i > compare. A mismatch in the same cycle as clear_i is discarded.
- Reset or clear mid-skew: in-flight A samples are dropped. No spurious valid mismatch, because WARMUP masks until the line refills.

Optional Feature:
Macro LOCKSTEP_SVA_EN.
- Defined:
  - Embedded concurrent assertion, @(posedge clk) disable iff (rst): !(armed_o && mismatch_o), i.e. A and B must be equivalent once armed.
  - Cover properties: reaching ARMED, and a compare cycle with both valids high.
  - Auxiliary assertion: mism_cnt_o never decreases except on clear_i.
- Undefined: no properties compiled; functional behaviour identical.

Test Plan:
- LANES=2, WIDTH=4, SKEW=0: identical valid data for 20 cycles -> mismatch_o=0, err_sticky_o=0, mism_cnt_o=0, armed_o=1 from cycle 2.
- SKEW=3: B = A delayed 3 cycles; inject b lane1=4'hA vs a lane1=4'h5 at one sample -> mismatch_o=1 one cycle later, lane_mism_o=2'b10, first_lane_o=1, first_a_o=5, first_b_o=A, mism_cnt_o=1.
- a_valid_i=1 while delayed B has b_valid_i=0 (ARMED) -> mismatch_o=1, first_lane_o=2 (LANES), first_a_o=first_b_o=0.
- CNT_W=3, 10 consecutive mismatches -> mism_cnt_o stops at 7; captures unchanged after the first.
- clear_i asserted in FAULT, simultaneously with a mismatch -> next cycle all outputs 0, state WARMUP, counter 0; re-arms after max(SKEW,1) cycles.
- rst asserted with SKEW=3 and 2 A samples in flight; B valid immediately after -> no mismatch during warm-up, armed_o=1 after 3 cycles.

Source files
------------

// File: rtl/lockstep_compare_monitor.sv
// rtl/lockstep_compare_monitor.sv - lane-by-lane lockstep comparator with sticky fault capture
//
// Compares the outputs of two copies of the same circuit (A and B). A is delayed
// SKEW cycles to line up with B. After a warm-up of max(SKEW,1) cycles every
// compare cycle (either side valid) is checked. The first mismatch latches the
// lane and values and makes the fault sticky. Mismatching compare cycles are
// counted with saturation.
//
// Optional: define LOCKSTEP_SVA_EN to compile the embedded assertions and covers.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   a_valid_i/a_data_i  A side outputs, lane k at [k*WIDTH +: WIDTH]
//   b_valid_i/b_data_i  B side outputs, same packing
//   clear_i         synchronous clear of all monitor state
//   armed_o         compares enabled (ARMED or FAULT)
//   mismatch_o      registered per-cycle mismatch pulse
//   lane_mism_o     registered per-lane mismatch vector
//   err_sticky_o    a mismatch has been seen (FAULT)
//   mism_cnt_o      saturating count of mismatching compare cycles
//   first_lane_o    lane of first mismatch (LANES = valid mismatch)
//   first_a_o/first_b_o  lane values at first mismatch
module lockstep_compare_monitor #(
    parameter int LANES  = 2,
    parameter int WIDTH  = 1,
    parameter int SKEW   = 0,
    parameter int CNT_W  = 8,
    parameter int LIDX_W = $clog2(LANES + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a_valid_i,
    input  logic [LANES*WIDTH-1:0]   a_data_i,
    input  logic                     b_valid_i,
    input  logic [LANES*WIDTH-1:0]   b_data_i,
    input  logic                     clear_i,
    output logic                     armed_o,
    output logic                     mismatch_o,
    output logic [LANES-1:0]         lane_mism_o,
    output logic                     err_sticky_o,
    output logic [CNT_W-1:0]         mism_cnt_o,
    output logic [LIDX_W-1:0]        first_lane_o,
    output logic [WIDTH-1:0]         first_a_o,
    output logic [WIDTH-1:0]         first_b_o
);

    localparam int WU   = (SKEW > 0) ? SKEW : 1;
    localparam int WU_W = (WU > 1) ? $clog2(WU) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_WARMUP = 2'd0,
        S_ARMED  = 2'd1,
        S_FAULT  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // rst and clear_i have identical effect on monitor state
    logic restart;
    assign restart = rst | clear_i;

    // ---------------- A-side delay line ----------------
    logic                   da_valid;
    logic [LANES*WIDTH-1:0] da_data;

    generate
        if (SKEW == 0) begin : g_nodly
            assign da_valid = a_valid_i;
            assign da_data  = a_data_i;
        end else begin : g_dly
            logic                   dv_q [SKEW];
            logic [LANES*WIDTH-1:0] dd_q [SKEW];

            always_ff @(posedge clk) begin
                if (restart) begin
                    for (int i = 0; i < SKEW; i++) begin
                        dv_q[i] <= 1'b0;
                        dd_q[i] <= '0;
                    end
                end else begin
                    dv_q[0] <= a_valid_i;
                    dd_q[0] <= a_data_i;
                    for (int i = 1; i < SKEW; i++) begin
                        dv_q[i] <= dv_q[i-1];
                        dd_q[i] <= dd_q[i-1];
                    end
                end
            end

            assign da_valid = dv_q[SKEW-1];
            assign da_data  = dd_q[SKEW-1];
        end
    endgenerate

    // ---------------- compare ----------------
    logic [LANES-1:0]  lane_neq;
    logic              valid_mism;
    logic              any_mism;
    logic              compare_en;
    logic [LIDX_W-1:0] cap_lane;
    logic [WIDTH-1:0]  cap_a;
    logic [WIDTH-1:0]  cap_b;

    always_comb begin
        lane_neq = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_neq[k] = da_valid & b_valid_i &
                          (da_data[k*WIDTH +: WIDTH] != b_data_i[k*WIDTH +: WIDTH]);
        end
        valid_mism = da_valid ^ b_valid_i;
        any_mism   = valid_mism | (|lane_neq);
        compare_en = (state_q != S_WARMUP);
    end

    // Lowest mismatching lane wins: scan downward so the last hit is the lowest.
    // A valid mismatch leaves lane_neq all-zero, so the LANES/0/0 defaults stand.
    always_comb begin
        cap_lane = LIDX_W'(LANES);
        cap_a    = '0;
        cap_b    = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (lane_neq[k]) begin
                cap_lane = LIDX_W'(k);
                cap_a    = da_data[k*WIDTH +: WIDTH];
                cap_b    = b_data_i[k*WIDTH +: WIDTH];
            end
        end
    end

    // ---------------- warm-up counter ----------------
    logic [WU_W-1:0] wu_cnt_q;
    logic            wu_done;
    assign wu_done = (wu_cnt_q == WU_W'(WU - 1));

    always_ff @(posedge clk) begin
        if (restart) begin
            wu_cnt_q <= '0;
        end else if (state_q == S_WARMUP && !wu_done) begin
            wu_cnt_q <= wu_cnt_q + 1'b1;
        end
    end

    // ---------------- state machine ----------------
    always_ff @(posedge clk) begin
        if (restart) begin
            state_q <= S_WARMUP;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WARMUP: if (wu_done)  state_d = S_ARMED;
            S_ARMED:  if (any_mism) state_d = S_FAULT;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_WARMUP;
        endcase
    end

    assign armed_o      = (state_q != S_WARMUP);
    assign err_sticky_o = (state_q == S_FAULT);

    // ---------------- registered results ----------------
    always_ff @(posedge clk) begin
        if (restart) begin
            mismatch_o   <= 1'b0;
            lane_mism_o  <= '0;
            mism_cnt_o   <= '0;
            first_lane_o <= '0;
            first_a_o    <= '0;
            first_b_o    <= '0;
        end else if (compare_en) begin
            mismatch_o  <= any_mism;
            lane_mism_o <= lane_neq;
            if (any_mism && mism_cnt_o != CNT_MAX) begin
                mism_cnt_o <= mism_cnt_o + 1'b1;
            end
            if (state_q == S_ARMED && any_mism) begin
                first_lane_o <= cap_lane;
                first_a_o    <= cap_a;
                first_b_o    <= cap_b;
            end
        end else begin
            mismatch_o  <= 1'b0;
            lane_mism_o <= '0;
        end
    end

`ifdef LOCKSTEP_SVA_EN
    a_equiv: assert property (@(posedge clk) disable iff (rst)
        !(armed_o && mismatch_o));

    a_cnt_mono: assert property (@(posedge clk) disable iff (rst)
        !clear_i |=> (mism_cnt_o >= $past(mism_cnt_o)));

    c_armed: cover property (@(posedge clk) disable iff (rst)
        state_q == S_ARMED);

    c_both_valid: cover property (@(posedge clk) disable iff (rst)
        compare_en && da_valid && b_valid_i);
`endif

endmodule

// File: tb/tb_lockstep_compare_monitor.sv
// tb/tb_lockstep_compare_monitor.sv - self-checking bench for lockstep_compare_monitor
module tb_lockstep_compare_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, clr, av, bv0, bv3;
    logic [7:0] ad, bd0, bd3;

    logic       arm0, mis0, err0, arm3, mis3, err3;
    logic [1:0] lm0, lm3, fl0, fl3;
    logic [7:0] cnt0;
    logic [2:0] cnt3;
    logic [3:0] fa0, fb0, fa3, fb3;

    lockstep_compare_monitor #(.LANES(2), .WIDTH(4), .SKEW(0), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .a_valid_i(av), .a_data_i(ad),
        .b_valid_i(bv0), .b_data_i(bd0), .clear_i(clr),
        .armed_o(arm0), .mismatch_o(mis0), .lane_mism_o(lm0), .err_sticky_o(err0),
        .mism_cnt_o(cnt0), .first_lane_o(fl0), .first_a_o(fa0), .first_b_o(fb0)
    );

    lockstep_compare_monitor #(.LANES(2), .WIDTH(4), .SKEW(3), .CNT_W(3)) u3 (
        .clk(clk), .rst(rst), .a_valid_i(av), .a_data_i(ad),
        .b_valid_i(bv3), .b_data_i(bd3), .clear_i(clr),
        .armed_o(arm3), .mismatch_o(mis3), .lane_mism_o(lm3), .err_sticky_o(err3),
        .mism_cnt_o(cnt3), .first_lane_o(fl3), .first_a_o(fa3), .first_b_o(fb3)
    );

    int checks = 0;
    int errors = 0;

    // bench-side history of A used to build a B stream lagging 3 cycles
    logic       pv [3];
    logic [7:0] pd [3];

    // reference model, index 0 = SKEW 0 / CNT_W 8, index 1 = SKEW 3 / CNT_W 3
    int         mk    [2];   // clean cycles since last rst/clear
    bit         mfault[2];
    int         mcnt  [2];
    bit         mmis  [2];
    int         mlane [2];
    int         mfl   [2];
    int         mfa   [2];
    int         mfb   [2];
    logic [8:0] mh    [2][16];

    function automatic int skew_of(int j); return (j == 0) ? 0 : 3; endfunction
    function automatic int wu_of(int j);   return (j == 0) ? 1 : 3; endfunction
    function automatic int cmax_of(int j); return (j == 0) ? 255 : 7; endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step(input int j, input logic bv, input logic [7:0] bd);
        int         c;
        int         neq;
        int         fl;
        logic       dv;
        logic [7:0] dd;
        logic       vm;
        if (rst || clr) begin
            mk[j] = 0; mfault[j] = 0; mcnt[j] = 0; mmis[j] = 0;
            mlane[j] = 0; mfl[j] = 0; mfa[j] = 0; mfb[j] = 0;
        end else begin
            c = mk[j];
            mh[j][c % 16] = {av, ad};
            if (c >= wu_of(j)) begin
                {dv, dd} = mh[j][(c - skew_of(j)) % 16];
                vm  = (dv != bv);
                neq = 0;
                if (dv && bv) begin
                    for (int l = 0; l < 2; l++)
                        if (dd[4*l +: 4] != bd[4*l +: 4]) neq |= (1 << l);
                end
                mmis[j]  = vm || (neq != 0);
                mlane[j] = neq;
                if (mmis[j]) begin
                    if (mcnt[j] < cmax_of(j)) mcnt[j]++;
                    if (!mfault[j]) begin
                        mfault[j] = 1;
                        if (vm) begin
                            mfl[j] = 2; mfa[j] = 0; mfb[j] = 0;
                        end else begin
                            fl = (neq & 1) ? 0 : 1;
                            mfl[j] = fl;
                            mfa[j] = int'(dd[4*fl +: 4]);
                            mfb[j] = int'(bd[4*fl +: 4]);
                        end
                    end
                end
            end else begin
                mmis[j]  = 0;
                mlane[j] = 0;
            end
            mk[j] = c + 1;
        end
    endtask

    task automatic check_dut(input int j, input string p, input logic arm, input logic mis,
                             input logic [1:0] lm, input logic err, input int cnt,
                             input int fl, input int fa, input int fb);
        chk({p, "armed"},  int'(arm), (mk[j] >= wu_of(j)) ? 1 : 0);
        chk({p, "mism"},   int'(mis), int'(mmis[j]));
        chk({p, "lane"},   int'(lm),  mlane[j]);
        chk({p, "sticky"}, int'(err), int'(mfault[j]));
        chk({p, "cnt"},    cnt, mcnt[j]);
        chk({p, "flane"},  fl, mfl[j]);
        chk({p, "fa"},     fa, mfa[j]);
        chk({p, "fb"},     fb, mfb[j]);
    endtask

    task automatic tick();
        model_step(0, bv0, bd0);
        model_step(1, bv3, bd3);
        @(posedge clk);
        pv[2] = pv[1]; pv[1] = pv[0]; pv[0] = av;
        pd[2] = pd[1]; pd[1] = pd[0]; pd[0] = ad;
        @(negedge clk);
        check_dut(0, "u0_", arm0, mis0, lm0, err0, int'(cnt0), int'(fl0), int'(fa0), int'(fb0));
        check_dut(1, "u3_", arm3, mis3, lm3, err3, int'(cnt3), int'(fl3), int'(fa3), int'(fb3));
    endtask

    task automatic drive_match(input logic [7:0] data);
        av  = 1'b1;
        ad  = data;
        bv0 = 1'b1;
        bd0 = data;
        bv3 = pv[2];
        bd3 = pd[2];
    endtask

    int r;

    initial begin
        for (int i = 0; i < 3; i++) begin pv[i] = 1'b0; pd[i] = '0; end
        rst = 1'b1; clr = 1'b0; av = 1'b0; ad = '0;
        bv0 = 1'b0; bd0 = '0; bv3 = 1'b0; bd3 = '0;
        tick(); tick();
        chk("reset_armed0", int'(arm0), 0);
        chk("reset_cnt3", int'(cnt3), 0);
        chk("reset_sticky3", int'(err3), 0);

        // identical streams
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive_match(8'($urandom));
            tick();
            if (i == 0) begin
                chk("arm0_after_1", int'(arm0), 1);
                chk("arm3_after_1", int'(arm3), 0);
            end
            if (i == 2) chk("arm3_after_3", int'(arm3), 1);
        end
        chk("match_sticky0", int'(err0), 0);
        chk("match_cnt0", int'(cnt0), 0);
        chk("match_sticky3", int'(err3), 0);

        // lane 1 injection on the skewed copy
        for (int i = 0; i < 5; i++) begin
            drive_match({4'h5, 4'($urandom)});
            if (i == 4) bd3[7:4] = 4'hA;
            tick();
        end
        chk("inj_mism3", int'(mis3), 1);
        chk("inj_lane3", int'(lm3), 2);
        chk("inj_flane3", int'(fl3), 1);
        chk("inj_fa3", int'(fa3), 5);
        chk("inj_fb3", int'(fb3), 10);
        chk("inj_cnt3", int'(cnt3), 1);

        // nine more mismatches: counter saturates at 7, capture unchanged
        for (int i = 0; i < 9; i++) begin
            drive_match({4'h5, 4'($urandom)});
            bd3[7:4] = 4'hA;
            tick();
        end
        chk("sat_cnt3", int'(cnt3), 7);
        chk("sat_flane3", int'(fl3), 1);
        chk("sat_fa3", int'(fa3), 5);
        chk("sat_fb3", int'(fb3), 10);

        // valid mismatch on the zero-skew copy
        drive_match(8'($urandom));
        bv0 = 1'b0; bd0 = '0;
        tick();
        chk("vm_mism0", int'(mis0), 1);
        chk("vm_lane0", int'(lm0), 0);
        chk("vm_flane0", int'(fl0), 2);
        chk("vm_fa0", int'(fa0), 0);
        chk("vm_fb0", int'(fb0), 0);

        // clear together with a mismatch
        clr = 1'b1;
        drive_match(8'($urandom));
        bv0 = 1'b0;
        tick();
        chk("clr_mism0", int'(mis0), 0);
        chk("clr_cnt0", int'(cnt0), 0);
        chk("clr_sticky0", int'(err0), 0);
        chk("clr_armed0", int'(arm0), 0);
        chk("clr_cnt3", int'(cnt3), 0);
        chk("clr_armed3", int'(arm3), 0);
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_match(8'($urandom));
            tick();
        end
        chk("rearm_armed0", int'(arm0), 1);
        chk("rearm_armed3", int'(arm3), 1);

        // reset with A samples in flight, B valid right after
        rst = 1'b1;
        drive_match(8'($urandom));
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_match(8'($urandom));
            tick();
            chk("inflight_mism3", int'(mis3), 0);
        end
        chk("inflight_armed3", int'(arm3), 1);

        // randomized traffic with sparse corruption, clears and resets
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            clr = ($urandom_range(0, 99) == 0);
            drive_match(8'($urandom));
            av  = ($urandom_range(0, 9) != 0);
            bv0 = av;
            r = int'($urandom_range(0, 39));
            case (r)
                0: bd0 = bd0 ^ (8'd1 << $urandom_range(0, 7));
                1: bv0 = ~bv0;
                2: bd3 = bd3 ^ (8'd1 << $urandom_range(0, 7));
                3: bv3 = ~bv3;
                default: ;
            endcase
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
